frame_catcher: RTL and testbench
================================

FRAME_CATCHER -- requirements
Module: frame_catcher

Interface
REQ-001 SHALL have parameter WORD_W, default 16, meaning input word width.
REQ-002 SHALL have parameter BEAT_WORDS, default 4, meaning words per output beat (legal values 2..8).
REQ-003 SHALL have parameter MAX_LEN, default 4096, meaning the largest accepted payload length in words.
REQ-004 SHALL have port CLK_250M, in, width 1: the single clock; reset is synchronous and active-low.
REQ-005 SHALL have port RST_N, in, width 1: synchronous, active-low reset.
REQ-006 SHALL have port DIN, in, width WORD_W: the line word.
REQ-007 SHALL have port DIN_K, in, width 1: the word is a K character.
REQ-008 SHALL have port DIN_VLD, in, width 1: the word is present.
REQ-009 SHALL have port OUT_READY, in, width 1: the downstream accepts a beat.
REQ-010 SHALL have port DOUT, out, width WORD_W*BEAT_WORDS: the output beat.
REQ-011 SHALL have ports DOUT_VLD, DOUT_LAST and DOUT_ERR, out, width 1 each: beat valid, last beat of frame, and frame aborted (qualifies LAST).
REQ-012 SHALL have ports FRM_CNT and ERR_CNT, out, width 16 each: counts of good and errored frames.

Function
REQ-013 SHALL frame input as: SOF (A0AA), SOF, KIND, LEN, LEN payload words, EOF (AAAA), EOF.
REQ-014 SHALL consume a word only when DIN_VLD=1 and DIN_K=0; all other cycles SHALL NOT advance the FSM or the packer.
REQ-015 SHALL implement FSM states HUNT, SOF2, KIND, LEN, PAYLOAD, EOF1, EOF2 and ABORT.
REQ-016 HUNT SHALL move to SOF2 on word==SOF, pushing that word into the packer.
REQ-017 SOF2 SHALL move to KIND on word==SOF and SHALL otherwise clear the packer silently and return to HUNT, with no error.
REQ-018 KIND SHALL move to LEN on the next consumed word.
REQ-019 LEN SHALL load a payload counter and move to PAYLOAD, or to EOF1 when LEN=0.
REQ-020 PAYLOAD SHALL move to EOF1 when the counter reaches 0; EOF1 SHALL move to EOF2; EOF2 SHALL move to HUNT.
REQ-021 Every consumed word from the first SOF through the second EOF SHALL be pushed into the packer, including SOFs, KIND, LEN and EOFs.
REQ-022 The packer SHALL place the first word of a beat in DOUT[WORD_W-1:0], ascending.
REQ-023 A beat SHALL be emitted on the cycle after its BEAT_WORDS-th word is consumed (1-cycle latency, registered output).
REQ-024 On EOF2 the partial beat SHALL be zero-filled and emitted immediately with DOUT_LAST=1 and DOUT_ERR=0.
REQ-025 A beat SHALL be held stable while DOUT_VLD=1 and OUT_READY=0; it SHALL be accepted on DOUT_VLD and OUT_READY.
REQ-026 If the slot is freed in the same cycle that a beat completes, the new beat SHALL be loaded with no overflow.
REQ-027 Overflow (a beat completes while the slot is held) SHALL discard that beat and the frame, and SHALL enter ABORT.
REQ-028 LEN>MAX_LEN SHALL enter ABORT after pushing the LEN word.
REQ-029 ABORT SHALL ignore input and, once the slot is free, emit the zero-filled partial beat (all zero if empty or after overflow) with DOUT_LAST=1 and DOUT_ERR=1, then go to HUNT.
REQ-030 FRM_CNT SHALL increment on acceptance of a beat with LAST=1 and ERR=0; ERR_CNT SHALL increment on LAST=1 and ERR=1.
REQ-031 FRM_CNT and ERR_CNT SHALL saturate at FFFF.

Reset
REQ-032 On RST_N=0 at a clock edge, the block SHALL set FSM=HUNT, clear the packer, and set DOUT, DOUT_VLD, DOUT_LAST, DOUT_ERR, FRM_CNT and ERR_CNT to 0.
REQ-033 Reset mid-frame SHALL discard the partial frame with no terminating beat.

Configuration
REQ-034 With FRAME_EOF_CHECK_EN defined, a word in EOF1 or EOF2 that is not equal to EOF SHALL enter ABORT after being pushed.
REQ-035 Without FRAME_EOF_CHECK_EN, the two trailer words SHALL be accepted unchecked.

Structure
REQ-036 Package frame_pkg SHALL hold SOF_WORD, EOF_WORD and the FSM state enum.
REQ-037 Word-to-beat packing, zero-fill and the hold slot SHALL be sub-module frame_word_packer.

Verification (WORD_W=16, BEAT_WORDS=4)
REQ-038 Input A0AA A0AA 0001 0003 1111 2222 3333 AAAA AAAA with OUT_READY=1 SHALL give beats 0003_0001_A0AA_A0AA, then AAAA_3333_2222_1111, then 0000_0000_0000_AAAA with LAST=1, and FRM_CNT=1.
REQ-039 The same frame with K words and DIN_VLD=0 gaps interleaved SHALL give identical beats.
REQ-040 Input A0AA A0AA 0001 1001 (LEN > MAX_LEN) SHALL give beat 1001_0001_A0AA_A0AA, then an all-zero beat with LAST=1 and ERR=1, and ERR_CNT=1.
REQ-041 The frame of REQ-038 with its last word 5555 SHALL give a final beat with ERR=1 when FRAME_EOF_CHECK_EN is defined, and a good frame (FRM_CNT=1) without it.
REQ-042 OUT_READY=0 throughout a 12-word frame SHALL give beat 1 held, then (after OUT_READY=1) a zero beat with LAST=1 and ERR=1; RST_N=0 mid-frame SHALL give DOUT_VLD=0 next cycle.

Source files
------------

// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_pkg
// Purpose  : Frame delimiter words and the catcher FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package frame_pkg;

    localparam logic [15:0] SOF_WORD = 16'hA0AA;
    localparam logic [15:0] EOF_WORD = 16'hAAAA;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_SOF2    = 3'd1,
        ST_KIND    = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_EOF1    = 3'd5,
        ST_EOF2    = 3'd6,
        ST_ABORT   = 3'd7
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : frame_word_packer
// Purpose  : Packs words into beats (word 0 in the LSBs), zero-fills partial
//            beats on flush and holds one output beat until accepted.
// Revision : 1.0 - initial release
// ============================================================================
module frame_word_packer #(
    parameter int WORD_W     = 16,
    parameter int BEAT_WORDS = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [WORD_W-1:0]            i_word,
    input  logic                         i_flush,
    input  logic                         i_flush_err,
    input  logic                         i_clear,
    input  logic                         i_ready,
    output logic [WORD_W*BEAT_WORDS-1:0] o_beat,
    output logic                         o_vld,
    output logic                         o_last,
    output logic                         o_err,
    output logic                         o_slot_free,
    output logic                         o_ovf
);

    localparam int                 c_CNT_W    = $clog2(BEAT_WORDS);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(BEAT_WORDS - 1);

    logic [BEAT_WORDS-1:0][WORD_W-1:0] r_acc;
    logic [BEAT_WORDS-1:0][WORD_W-1:0] r_beat;
    logic [BEAT_WORDS-1:0][WORD_W-1:0] w_beat;
    logic [c_CNT_W-1:0]                r_cnt;
    logic                              r_vld;
    logic                              r_last;
    logic                              r_err;
    logic                              w_emit;
    logic                              w_slot_free;

    // Unfilled lanes of r_acc are always zero, so a flush is zero-filled for free.
    always_comb begin
        w_beat = r_acc;
        if (i_push) begin
            w_beat[r_cnt] = i_word;
        end
    end

    assign w_emit      = (i_push && (r_cnt == c_LAST_IDX)) || i_flush;
    assign w_slot_free = !r_vld || i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            r_beat <= '0;
            r_cnt  <= '0;
            r_vld  <= 1'b0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (r_vld && i_ready) begin
                r_vld  <= 1'b0;
                r_last <= 1'b0;
                r_err  <= 1'b0;
            end
            if (i_clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_emit) begin
                // A completed beat with no free slot is dropped here; the FSM aborts.
                r_acc <= '0;
                r_cnt <= '0;
                if (w_slot_free) begin
                    r_beat <= w_beat;
                    r_vld  <= 1'b1;
                    r_last <= i_flush;
                    r_err  <= i_flush && i_flush_err;
                end
            end else if (i_push) begin
                r_acc <= w_beat;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_beat      = r_beat;
    assign o_vld       = r_vld;
    assign o_last      = r_last;
    assign o_err       = r_err;
    assign o_slot_free = w_slot_free;
    assign o_ovf       = w_emit && !w_slot_free;

endmodule
`default_nettype wire

// File: rtl/frame_catcher.sv
`default_nettype none
// ============================================================================
// Module   : frame_catcher
// Purpose  : Hunts SOF/SOF/KIND/LEN/payload/EOF/EOF frames and emits them as
//            beats. Define FRAME_EOF_CHECK_EN to abort on bad trailer words.
// Revision : 1.0 - initial release
// ============================================================================
module frame_catcher #(
    parameter int WORD_W     = 16,
    parameter int BEAT_WORDS = 4,
    parameter int MAX_LEN    = 4096
) (
    input  logic                         CLK_250M,
    input  logic                         RST_N,
    input  logic [WORD_W-1:0]            DIN,
    input  logic                         DIN_K,
    input  logic                         DIN_VLD,
    input  logic                         OUT_READY,
    output logic [WORD_W*BEAT_WORDS-1:0] DOUT,
    output logic                         DOUT_VLD,
    output logic                         DOUT_LAST,
    output logic                         DOUT_ERR,
    output logic [15:0]                  FRM_CNT,
    output logic [15:0]                  ERR_CNT
);

    import frame_pkg::*;

    localparam logic [WORD_W-1:0] c_SOF = WORD_W'(SOF_WORD);
`ifdef FRAME_EOF_CHECK_EN
    localparam logic [WORD_W-1:0] c_EOF = WORD_W'(EOF_WORD);
`endif

    frame_state_t      r_state;
    frame_state_t      w_next_raw;
    frame_state_t      w_next;
    logic [WORD_W-1:0] r_len_cnt;
    logic [WORD_W-1:0] w_len_nxt;
    logic [15:0]       r_frm_cnt;
    logic [15:0]       r_err_cnt;
    logic              w_take;
    logic              w_push;
    logic              w_flush;
    logic              w_flush_err;
    logic              w_clear;
    logic              w_slot_free;
    logic              w_ovf;
    logic              w_len_bad;

    assign w_take    = DIN_VLD && !DIN_K;
    assign w_len_bad = 64'(DIN) > 64'(MAX_LEN);

    always_comb begin
        w_next_raw  = r_state;
        w_len_nxt   = r_len_cnt;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        w_flush_err = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_HUNT: if (w_take && (DIN == c_SOF)) begin
                w_push     = 1'b1;
                w_next_raw = ST_SOF2;
            end
            ST_SOF2: if (w_take) begin
                if (DIN == c_SOF) begin
                    w_push     = 1'b1;
                    w_next_raw = ST_KIND;
                end else begin
                    w_clear    = 1'b1;
                    w_next_raw = ST_HUNT;
                end
            end
            ST_KIND: if (w_take) begin
                w_push     = 1'b1;
                w_next_raw = ST_LEN;
            end
            ST_LEN: if (w_take) begin
                w_push    = 1'b1;
                w_len_nxt = DIN;
                if (w_len_bad)           w_next_raw = ST_ABORT;
                else if (DIN == '0)      w_next_raw = ST_EOF1;
                else                     w_next_raw = ST_PAYLOAD;
            end
            ST_PAYLOAD: if (w_take) begin
                w_push    = 1'b1;
                w_len_nxt = r_len_cnt - 1'b1;
                if (r_len_cnt == WORD_W'(1)) w_next_raw = ST_EOF1;
            end
            ST_EOF1: if (w_take) begin
                w_push     = 1'b1;
                w_next_raw = ST_EOF2;
`ifdef FRAME_EOF_CHECK_EN
                if (DIN != c_EOF) w_next_raw = ST_ABORT;
`endif
            end
            ST_EOF2: if (w_take) begin
                w_push     = 1'b1;
                w_flush    = 1'b1;
                w_next_raw = ST_HUNT;
`ifdef FRAME_EOF_CHECK_EN
                // Keep the bad word in the partial beat; ABORT flushes it with ERR.
                if (DIN != c_EOF) begin
                    w_flush    = 1'b0;
                    w_next_raw = ST_ABORT;
                end
`endif
            end
            ST_ABORT: if (w_slot_free) begin
                w_flush     = 1'b1;
                w_flush_err = 1'b1;
                w_next_raw  = ST_HUNT;
            end
            default: w_next_raw = ST_HUNT;
        endcase
    end

    // Overflow is resolved after the packer sees this cycle's push/flush.
    assign w_next = w_ovf ? ST_ABORT : w_next_raw;

    always_ff @(posedge CLK_250M) begin
        if (!RST_N) begin
            r_state   <= ST_HUNT;
            r_len_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_len_cnt <= w_len_nxt;
        end
    end

    always_ff @(posedge CLK_250M) begin
        if (!RST_N) begin
            r_frm_cnt <= '0;
            r_err_cnt <= '0;
        end else if (DOUT_VLD && OUT_READY && DOUT_LAST) begin
            if (DOUT_ERR) begin
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end else begin
                if (r_frm_cnt != 16'hFFFF) r_frm_cnt <= r_frm_cnt + 16'd1;
            end
        end
    end

    frame_word_packer #(
        .WORD_W     (WORD_W),
        .BEAT_WORDS (BEAT_WORDS)
    ) u_packer (
        .i_clk       (CLK_250M),
        .i_rst_n     (RST_N),
        .i_push      (w_push),
        .i_word      (DIN),
        .i_flush     (w_flush),
        .i_flush_err (w_flush_err),
        .i_clear     (w_clear),
        .i_ready     (OUT_READY),
        .o_beat      (DOUT),
        .o_vld       (DOUT_VLD),
        .o_last      (DOUT_LAST),
        .o_err       (DOUT_ERR),
        .o_slot_free (w_slot_free),
        .o_ovf       (w_ovf)
    );

    assign FRM_CNT = r_frm_cnt;
    assign ERR_CNT = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_catcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_frame_catcher
// Purpose  : Scoreboard bench for frame_catcher (WORD_W=16, BEAT_WORDS=4);
//            expectations follow FRAME_EOF_CHECK_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_catcher;

    logic        CLK_250M;
    logic        RST_N;
    logic [15:0] DIN;
    logic        DIN_K;
    logic        DIN_VLD;
    logic        OUT_READY;
    logic [63:0] DOUT;
    logic        DOUT_VLD;
    logic        DOUT_LAST;
    logic        DOUT_ERR;
    logic [15:0] FRM_CNT;
    logic [15:0] ERR_CNT;

    int          tests_run;
    int          fails;
    int          exp_frm;
    int          exp_err;
    logic [65:0] exp_q[$];
    logic [65:0] rx_q[$];
    logic [15:0] stim_q[$];

    frame_catcher #(
        .WORD_W     (16),
        .BEAT_WORDS (4),
        .MAX_LEN    (4096)
    ) dut (
        .CLK_250M  (CLK_250M),
        .RST_N     (RST_N),
        .DIN       (DIN),
        .DIN_K     (DIN_K),
        .DIN_VLD   (DIN_VLD),
        .OUT_READY (OUT_READY),
        .DOUT      (DOUT),
        .DOUT_VLD  (DOUT_VLD),
        .DOUT_LAST (DOUT_LAST),
        .DOUT_ERR  (DOUT_ERR),
        .FRM_CNT   (FRM_CNT),
        .ERR_CNT   (ERR_CNT)
    );

    initial CLK_250M = 1'b0;
    always #2 CLK_250M = ~CLK_250M;

    // A beat is accepted at the posedge following a negedge that sees VLD && READY.
    always @(negedge CLK_250M) begin
        if (RST_N && DOUT_VLD && OUT_READY) rx_q.push_back({DOUT, DOUT_LAST, DOUT_ERR});
    end

    function automatic logic [65:0] mk(input logic [63:0] d, input logic last, input logic err);
        return {d, last, err};
    endfunction

    task automatic put(input logic [15:0] w, input logic k, input logic v);
        DIN     = w;
        DIN_K   = k;
        DIN_VLD = v;
        @(posedge CLK_250M);
        #1;
    endtask

    task automatic send_stim();
        foreach (stim_q[i]) put(stim_q[i], 1'b0, 1'b1);
        DIN_VLD = 1'b0;
    endtask

    task automatic wait_rx();
        for (int c = 0; c < 60 && rx_q.size() < exp_q.size(); c++) @(posedge CLK_250M);
        repeat (4) @(posedge CLK_250M);
        #1;
    endtask

    task automatic load_good_frame(input logic [15:0] last_word);
        stim_q = '{16'hA0AA, 16'hA0AA, 16'h0001, 16'h0003, 16'h1111, 16'h2222,
                   16'h3333, 16'hAAAA, last_word};
    endtask

    task automatic test_reset();
        RST_N = 1'b0; DIN = '0; DIN_K = 1'b0; DIN_VLD = 1'b0; OUT_READY = 1'b1;
        repeat (3) @(posedge CLK_250M);
        #1;
        tests_run++; if (DOUT !== 64'h0) begin fails++; $display("FAIL reset_dout got %h want 0", DOUT); end
        tests_run++; if ({DOUT_VLD, DOUT_LAST, DOUT_ERR} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {DOUT_VLD, DOUT_LAST, DOUT_ERR}); end
        tests_run++; if ({FRM_CNT, ERR_CNT} !== 32'h0) begin fails++; $display("FAIL reset_counts got %h/%h want 0/0", FRM_CNT, ERR_CNT); end
        RST_N = 1'b1;
        @(posedge CLK_250M);
        #1;
    endtask

    task automatic test_good_frame();
        exp_q = {}; rx_q = {};
        exp_q.push_back(mk(64'h0003_0001_A0AA_A0AA, 1'b0, 1'b0));
        exp_q.push_back(mk(64'hAAAA_3333_2222_1111, 1'b0, 1'b0));
        exp_q.push_back(mk(64'h0000_0000_0000_AAAA, 1'b1, 1'b0));
        exp_frm++;
        load_good_frame(16'hAAAA);
        foreach (stim_q[i]) begin
            put(stim_q[i], 1'b0, 1'b1);
            if (i == 2) begin
                tests_run++; if (DOUT_VLD !== 1'b0) begin fails++; $display("FAIL latency_early vld got %b want 0", DOUT_VLD); end
            end
            if (i == 3) begin
                tests_run++; if (DOUT_VLD !== 1'b1) begin fails++; $display("FAIL latency_one vld got %b want 1", DOUT_VLD); end
            end
        end
        DIN_VLD = 1'b0;
        wait_rx();
        tests_run++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL good_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests_run++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL good_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        tests_run++; if (FRM_CNT !== 16'(exp_frm)) begin fails++; $display("FAIL good_frm_cnt got %0d want %0d", FRM_CNT, exp_frm); end
    endtask

    task automatic test_gaps();
        exp_q = {}; rx_q = {};
        exp_q.push_back(mk(64'h0003_0001_A0AA_A0AA, 1'b0, 1'b0));
        exp_q.push_back(mk(64'hAAAA_3333_2222_1111, 1'b0, 1'b0));
        exp_q.push_back(mk(64'h0000_0000_0000_AAAA, 1'b1, 1'b0));
        exp_frm++;
        load_good_frame(16'hAAAA);
        foreach (stim_q[i]) begin
            if (i % 3 == 0) put(16'hA0AA, 1'b1, 1'b1);
            put(stim_q[i], 1'b0, 1'b1);
            if (i % 2 == 0) put(16'hAAAA, 1'b0, 1'b0);
            if (i == 5) put(16'h5555, 1'b1, 1'b1);
        end
        DIN_VLD = 1'b0;
        wait_rx();
        tests_run++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL gaps_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests_run++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL gaps_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        tests_run++; if (FRM_CNT !== 16'(exp_frm)) begin fails++; $display("FAIL gaps_frm_cnt got %0d want %0d", FRM_CNT, exp_frm); end
    endtask

    task automatic test_len_abort();
        exp_q = {}; rx_q = {};
        exp_q.push_back(mk(64'h1001_0001_A0AA_A0AA, 1'b0, 1'b0));
        exp_q.push_back(mk(64'h0, 1'b1, 1'b1));
        exp_err++;
        stim_q = '{16'hA0AA, 16'hA0AA, 16'h0001, 16'h1001};
        send_stim();
        wait_rx();
        tests_run++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL len_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests_run++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL len_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        tests_run++; if (ERR_CNT !== 16'(exp_err)) begin fails++; $display("FAIL len_err_cnt got %0d want %0d", ERR_CNT, exp_err); end
    endtask

    task automatic test_eof_check();
        exp_q = {}; rx_q = {};
        exp_q.push_back(mk(64'h0003_0001_A0AA_A0AA, 1'b0, 1'b0));
        exp_q.push_back(mk(64'hAAAA_3333_2222_1111, 1'b0, 1'b0));
`ifdef FRAME_EOF_CHECK_EN
        exp_q.push_back(mk(64'h0000_0000_0000_5555, 1'b1, 1'b1));
        exp_err++;
`else
        exp_q.push_back(mk(64'h0000_0000_0000_5555, 1'b1, 1'b0));
        exp_frm++;
`endif
        load_good_frame(16'h5555);
        send_stim();
        wait_rx();
        tests_run++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL eof_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests_run++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL eof_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        tests_run++; if ({FRM_CNT, ERR_CNT} !== {16'(exp_frm), 16'(exp_err)}) begin fails++; $display("FAIL eof_counts got %0d/%0d want %0d/%0d", FRM_CNT, ERR_CNT, exp_frm, exp_err); end
    endtask

    task automatic test_backpressure();
        exp_q = {}; rx_q = {};
        exp_q.push_back(mk(64'h0006_0001_A0AA_A0AA, 1'b0, 1'b0));
        exp_q.push_back(mk(64'h0, 1'b1, 1'b1));
        exp_err++;
        OUT_READY = 1'b0;
        stim_q = '{16'hA0AA, 16'hA0AA, 16'h0001, 16'h0006, 16'h0101, 16'h0202,
                   16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'hAAAA, 16'hAAAA};
        send_stim();
        repeat (3) @(posedge CLK_250M);
        #1;
        tests_run++; if ({DOUT_VLD, DOUT} !== {1'b1, 64'h0006_0001_A0AA_A0AA}) begin fails++; $display("FAIL hold_beat got %b/%h want 1/0006_0001_a0aa_a0aa", DOUT_VLD, DOUT); end
        OUT_READY = 1'b1;
        wait_rx();
        tests_run++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL ovf_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests_run++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        tests_run++; if (ERR_CNT !== 16'(exp_err)) begin fails++; $display("FAIL ovf_err_cnt got %0d want %0d", ERR_CNT, exp_err); end
    endtask

    task automatic test_back_to_back();
        exp_q = {}; rx_q = {};
        exp_q.push_back(mk(64'h0003_0001_A0AA_A0AA, 1'b0, 1'b0));
        exp_q.push_back(mk(64'hAAAA_3333_2222_1111, 1'b0, 1'b0));
        exp_q.push_back(mk(64'h0000_0000_0000_AAAA, 1'b1, 1'b0));
        exp_frm++;
        load_good_frame(16'hAAAA);
        OUT_READY = 1'b0;
        foreach (stim_q[i]) begin
            if (i == 7) OUT_READY = 1'b1;
            put(stim_q[i], 1'b0, 1'b1);
        end
        DIN_VLD = 1'b0;
        wait_rx();
        tests_run++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests_run++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        tests_run++; if ({FRM_CNT, ERR_CNT} !== {16'(exp_frm), 16'(exp_err)}) begin fails++; $display("FAIL b2b_counts got %0d/%0d want %0d/%0d", FRM_CNT, ERR_CNT, exp_frm, exp_err); end
    endtask

    task automatic test_reset_mid_frame();
        OUT_READY = 1'b0;
        stim_q = '{16'hA0AA, 16'hA0AA, 16'h0001, 16'h0003, 16'h1111};
        send_stim();
        RST_N = 1'b0;
        @(posedge CLK_250M);
        #1;
        tests_run++; if (DOUT_VLD !== 1'b0) begin fails++; $display("FAIL midrst_vld got %b want 0", DOUT_VLD); end
        tests_run++; if ({FRM_CNT, ERR_CNT} !== 32'h0) begin fails++; $display("FAIL midrst_counts got %0d/%0d want 0/0", FRM_CNT, ERR_CNT); end
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        exp_frm = 1;
        exp_err = 0;
        exp_q = {}; rx_q = {};
        exp_q.push_back(mk(64'h0003_0001_A0AA_A0AA, 1'b0, 1'b0));
        exp_q.push_back(mk(64'hAAAA_3333_2222_1111, 1'b0, 1'b0));
        exp_q.push_back(mk(64'h0000_0000_0000_AAAA, 1'b1, 1'b0));
        load_good_frame(16'hAAAA);
        send_stim();
        wait_rx();
        tests_run++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL midrst_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests_run++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL midrst_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        tests_run++; if ({FRM_CNT, ERR_CNT} !== {16'(exp_frm), 16'(exp_err)}) begin fails++; $display("FAIL midrst_after got %0d/%0d want %0d/%0d", FRM_CNT, ERR_CNT, exp_frm, exp_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        fails     = 0;
        exp_frm   = 0;
        exp_err   = 0;
        test_reset();
        test_good_frame();
        test_gaps();
        test_len_abort();
        test_eof_check();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
